timer: RTL and testbench
========================

# timer

Memory-mapped 32-bit down-counting timer on the system bridge; it is the interrupt source upstream of the CP0 block. The CPU programs it through a three-register window (CTRL, PRESET, COUNT). On expiry it raises `IRQ`, which drives CP0 `HWInt[0]`. It supports two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

## Interface
Parameters:
- none; register offsets, mode codes and state encodings are shared constants.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Addr`  in  2  word offset, address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `Wen`  in  1  write enable, sampled on rising edge.
- `Din`  in  32  write data.
- `DOut`  out  32  combinational read of the register selected by `Addr`; unmapped offsets read 0.
- `IRQ`  out  1  interrupt request to CP0 `HWInt[0]`, equal to `irq_flag & CTRL.IM`.

## Operation
- CTRL fields:
  - [0] Enable.
  - [2:1] Mode: 0 = one-shot, 1 = auto-reload; codes 2 and 3 behave as 0.
  - [3] IM, the interrupt mask (1 = IRQ allowed).
  - Bits [31:4] are not stored and read 0.
- PRESET is a 32-bit reload value and is fully read/write.
- COUNT is read-only. Writes to offsets 2 and 3 are ignored.
- FSM states are IDLE, LOAD, CNT and INT.
  - IDLE: if Enable = 1, go to LOAD; otherwise stay and hold COUNT.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT with Enable = 0: go to IDLE and freeze COUNT.
  - CNT with COUNT > 1: COUNT <= COUNT - 1.
  - CNT with COUNT <= 1: COUNT <= 0, irq_flag <= 1, go to INT. PRESET = 0 therefore expires on the first CNT cycle.
  - INT in mode 0: clear Enable, go to IDLE. irq_flag stays held.
  - INT in mode 1: clear irq_flag, go to LOAD. If Enable was cleared, go to IDLE instead.
- irq_flag is cleared by any write to CTRL or PRESET. This is the one-shot acknowledge.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state Enable clear wins; the written value is kept.
  - A PRESET write in CNT does not alter the running COUNT; it takes effect at the next LOAD.
  - A CTRL write with Enable = 0 is seen by the FSM on the following edge.
  - A CTRL write and the irq_flag set in the same edge: the clear wins.
- Reset, including mid-count: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE. `IRQ` = 0 and `DOut` reflects the zeroed registers immediately.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.

## Timing
- A register write is visible on `DOut` the cycle after edge E.
- Enable written at edge E with PRESET = N, N >= 1:
  - state LOAD after E+1;
  - COUNT = N and state CNT after E+2;
  - COUNT = 0, state INT and irq_flag = 1 after E+2+N.
- Mode 0: `IRQ` is high from E+2+N until the edge of the acknowledging write.
- Mode 1: `IRQ` is high for exactly one cycle, E+2+N to E+3+N. Subsequent pulses occur every N+2 cycles.
- `IRQ` and `DOut` are combinational from registers only; there is no path from `Din` to `IRQ`.

## Structure
- The existing shared macro include gains:
  - register offsets `TMR_CTRL`, `TMR_PRESET`, `TMR_COUNT`;
  - CTRL bit positions;
  - mode codes `TMR_MODE_ONESHOT` and `TMR_MODE_RELOAD`;
  - FSM state encodings.
- Single module; no sub-module is warranted.
- The `IRQ` to `HWInt[0]` binding is made in the bridge/top level, not in this block.

## Test plan
1. Reset mid-count: reset asserted with COUNT = 5 in CNT, checked asynchronously before the next edge → CTRL, PRESET, COUNT and `IRQ` all read 0, state IDLE.
2. One-shot: PRESET = 3, CTRL = 0b1001 → COUNT reads 3, 2, 1, 0; `IRQ` = 1 from E+5 and held; Enable reads 0; a PRESET write drops `IRQ` on the next cycle.
3. Auto-reload: PRESET = 2, CTRL = 0b1011 → single-cycle `IRQ` pulses every 4 cycles, first at E+4; COUNT reloads to 2.
4. Mask: PRESET = 1, CTRL = 0b0001 → COUNT reaches 0 with `IRQ` = 0 throughout; then writing CTRL = 0b1000 keeps `IRQ` = 0, because the write acknowledges the held flag.
5. Pause and PRESET=0: in CNT at COUNT = 7, write CTRL = 0 → COUNT frozen at 6; writing PRESET = 0 then Enable = 1 → INT reached on the first CNT cycle.
6. Register window: writes to offsets 2 and 3 with 0xFFFF_FFFF are ignored (COUNT unchanged, offset 3 reads 0); CTRL written 0xFFFF_FFFF reads back 0x0000_000F.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register
// offsets, CTRL bit positions, mode codes and FSM state encodings.
package timer_pkg;

  typedef logic [1:0] tmr_addr_t;

  localparam tmr_addr_t TMR_CTRL   = 2'd0;
  localparam tmr_addr_t TMR_PRESET = 2'd1;
  localparam tmr_addr_t TMR_COUNT  = 2'd2;

  localparam int TMR_CTRL_EN      = 0;
  localparam int TMR_CTRL_MODE_LO = 1;
  localparam int TMR_CTRL_MODE_HI = 2;
  localparam int TMR_CTRL_IM      = 3;

  localparam logic [1:0] TMR_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] TMR_MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_t;

  // Only the low four CTRL bits are stored; the packed layout matches CTRL[3:0].
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

  function automatic tmr_ctrl_t ctrl_from_word(input logic [31:0] w);
    tmr_ctrl_t c;
    c.im   = w[TMR_CTRL_IM];
    c.mode = w[TMR_CTRL_MODE_HI:TMR_CTRL_MODE_LO];
    c.en   = w[TMR_CTRL_EN];
    return c;
  endfunction

endpackage

// File: rtl/timer_if.sv
// Register-window bus between the system bridge (master) and the timer (slave).
interface timer_if;
  import timer_pkg::*;

  tmr_addr_t   Addr;
  logic        Wen;
  logic [31:0] Din;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, output Wen, output Din, input DOut, input IRQ);
  modport slave  (input Addr, input Wen, input Din, output DOut, output IRQ);

endinterface

// File: rtl/timer.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT window; raises IRQ on
// expiry, held in one-shot mode and pulsed for one cycle in auto-reload mode.
module timer
  import timer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  timer_if.slave  bus
);

  tmr_state_t  state_q, state_d;
  tmr_ctrl_t   ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic wr_ctrl, wr_preset;
  logic reload, en_clr, flag_set, flag_clr;

  assign wr_ctrl   = bus.Wen && (bus.Addr == TMR_CTRL);
  assign wr_preset = bus.Wen && (bus.Addr == TMR_PRESET);

  always_comb begin : fsm_next
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    en_clr   = 1'b0;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    reload   = 1'b0;

    case (ctrl_q.mode)
      TMR_MODE_RELOAD:  reload = 1'b1;
      TMR_MODE_ONESHOT: reload = 1'b0;
      default:          reload = 1'b0;
    endcase

    case (state_q)
      TMR_IDLE: begin
        if (ctrl_q.en) state_d = TMR_LOAD;
      end
      TMR_LOAD: begin
        count_d = preset_q;
        state_d = TMR_CNT;
      end
      TMR_CNT: begin
        if (!ctrl_q.en) begin
          state_d = TMR_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers COUNT = 0 too, so a zero PRESET expires without wrapping.
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = TMR_INT;
        end
      end
      TMR_INT: begin
        if (reload) begin
          flag_clr = 1'b1;
          state_d  = ctrl_q.en ? TMR_LOAD : TMR_IDLE;
        end else begin
          en_clr  = 1'b1;
          state_d = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  always_comb begin : reg_next
    ctrl_d = ctrl_q;
    if (en_clr) ctrl_d.en = 1'b0;
    // A CPU write to CTRL overrides the one-shot Enable clear.
    if (wr_ctrl) ctrl_d = ctrl_from_word(bus.Din);

    preset_d = wr_preset ? bus.Din : preset_q;

    irq_flag_d = irq_flag_q;
    if (flag_set) irq_flag_d = 1'b1;
    // Writes to CTRL or PRESET acknowledge, and win over a same-edge expiry.
    if (flag_clr || wr_ctrl || wr_preset) irq_flag_d = 1'b0;
  end

  // NOTE: the asynchronous reset clears every register; there is no array
  // here, so nothing is left for software to initialise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TMR_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin : read_mux
    bus.DOut = '0;
    case (bus.Addr)
      TMR_CTRL:   bus.DOut = {28'd0, ctrl_q};
      TMR_PRESET: bus.DOut = preset_q;
      TMR_COUNT:  bus.DOut = count_q;
      default:    bus.DOut = '0;
    endcase
  end

  assign bus.IRQ = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios with literal expectations
// plus randomized register traffic compared every cycle against a model.
module tb_timer;
  import timer_pkg::*;

  logic clk;
  logic reset;
  timer_if bus ();

  timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: software-visible registers plus where the timer is in
  // its life cycle (waiting, about to load, counting, just expired).
  localparam logic [1:0] M_WAIT = 2'd0, M_ARM = 2'd1, M_RUN = 2'd2, M_DONE = 2'd3;

  typedef struct packed {
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic [1:0]  phase;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_step(input mdl_t c, input logic wen,
                                    input logic [1:0] a, input logic [31:0] d);
    mdl_t n;
    n = c;
    if (c.phase == M_WAIT) begin
      if (c.en) n.phase = M_ARM;
    end else if (c.phase == M_ARM) begin
      n.count = c.preset;
      n.phase = M_RUN;
    end else if (c.phase == M_RUN) begin
      if (!c.en) n.phase = M_WAIT;
      else if (c.count > 1) n.count = c.count - 1;
      else begin
        n.count = 0;
        n.flag  = 1'b1;
        n.phase = M_DONE;
      end
    end else begin
      if (c.mode == 2'd1) begin
        n.flag  = 1'b0;
        n.phase = c.en ? M_ARM : M_WAIT;
      end else begin
        n.en    = 1'b0;
        n.phase = M_WAIT;
      end
    end
    if (wen && a == 2'd0) begin
      n.en   = d[0];
      n.mode = d[2:1];
      n.im   = d[3];
      n.flag = 1'b0;
    end
    if (wen && a == 2'd1) begin
      n.preset = d;
      n.flag   = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] mdl_read(input mdl_t c, input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, c.im, c.mode, c.en};
      2'd1:    return c.preset;
      2'd2:    return c.count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= mdl_step(m, bus.Wen, bus.Addr, bus.Din);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_dout", bus.DOut, mdl_read(m, bus.Addr));
      check("model_irq", {31'd0, bus.IRQ}, {31'd0, m.flag & m.im});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Wen  = 1'b1;
    bus.Addr = a;
    bus.Din  = d;
    @(posedge clk);
    #1;
    bus.Wen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check(name, bus.DOut, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'd0, bus.IRQ}, {31'd0, exp});
  endtask

  initial begin
    bus.Wen  = 1'b0;
    bus.Addr = TMR_CTRL;
    bus.Din  = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk_reg("por_ctrl", TMR_CTRL, 32'd0);
    chk_reg("por_preset", TMR_PRESET, 32'd0);
    chk_reg("por_count", TMR_COUNT, 32'd0);
    chk_irq("por_irq", 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    cmp_on = 1'b1;

    // Reset in the middle of a count, checked before the next edge.
    wr(TMR_PRESET, 32'd5);
    wr(TMR_CTRL, 32'd9);
    idle(2);
    chk_reg("mid_count_pre", TMR_COUNT, 32'd5);
    #1 reset = 1'b1;
    chk_reg("rst_ctrl", TMR_CTRL, 32'd0);
    chk_reg("rst_preset", TMR_PRESET, 32'd0);
    chk_reg("rst_count", TMR_COUNT, 32'd0);
    chk_irq("rst_irq", 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // One-shot, PRESET = 3.
    wr(TMR_PRESET, 32'd3);
    wr(TMR_CTRL, 32'd9);
    idle(2);
    chk_reg("os_count_e2", TMR_COUNT, 32'd3);
    idle(1);
    chk_reg("os_count_e3", TMR_COUNT, 32'd2);
    idle(1);
    chk_reg("os_count_e4", TMR_COUNT, 32'd1);
    chk_irq("os_irq_e4", 1'b0);
    idle(1);
    chk_reg("os_count_e5", TMR_COUNT, 32'd0);
    chk_irq("os_irq_e5", 1'b1);
    idle(1);
    chk_reg("os_enable_cleared", TMR_CTRL, 32'd8);
    idle(3);
    chk_irq("os_irq_held", 1'b1);
    wr(TMR_PRESET, 32'd3);
    chk_irq("os_irq_ack", 1'b0);

    // Auto-reload, PRESET = 2: pulses at E+4, E+8, E+12.
    wr(TMR_PRESET, 32'd2);
    wr(TMR_CTRL, 32'd11);
    for (int k = 1; k <= 13; k++) begin
      idle(1);
      chk_irq($sformatf("ar_irq_e%0d", k), (k % 4) == 0);
      if (k == 6) chk_reg("ar_reload", TMR_COUNT, 32'd2);
    end
    wr(TMR_CTRL, 32'd0);
    idle(3);

    // Masked expiry; a later CTRL write acknowledges the hidden flag.
    wr(TMR_PRESET, 32'd1);
    wr(TMR_CTRL, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
      if (k == 3) chk_reg("mask_count_zero", TMR_COUNT, 32'd0);
    end
    chk_reg("mask_en_cleared", TMR_CTRL, 32'd0);
    wr(TMR_CTRL, 32'd8);
    chk_irq("mask_unmask_irq", 1'b0);
    chk_reg("mask_ctrl", TMR_CTRL, 32'd8);

    // Pause at COUNT = 7.
    wr(TMR_PRESET, 32'd10);
    wr(TMR_CTRL, 32'd1);
    idle(5);
    chk_reg("pause_count7", TMR_COUNT, 32'd7);
    wr(TMR_CTRL, 32'd0);
    chk_reg("pause_count6", TMR_COUNT, 32'd6);
    idle(3);
    chk_reg("pause_frozen", TMR_COUNT, 32'd6);

    // Register window: COUNT and offset 3 ignore writes.
    wr(TMR_COUNT, 32'hFFFF_FFFF);
    chk_reg("win_count_ro", TMR_COUNT, 32'd6);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_reg("win_off3", 2'd3, 32'd0);
    chk_reg("win_count_kept", TMR_COUNT, 32'd6);
    chk_reg("win_preset_kept", TMR_PRESET, 32'd10);
    chk_reg("win_ctrl_kept", TMR_CTRL, 32'd0);

    // PRESET = 0 expires on the first counting cycle.
    wr(TMR_PRESET, 32'd0);
    wr(TMR_CTRL, 32'd9);
    idle(2);
    chk_irq("zero_irq_e2", 1'b0);
    chk_reg("zero_count_e2", TMR_COUNT, 32'd0);
    idle(1);
    chk_irq("zero_irq_e3", 1'b1);
    wr(TMR_PRESET, 32'd0);
    chk_irq("zero_ack", 1'b0);

    wr(TMR_CTRL, 32'hFFFF_FFFF);
    chk_reg("win_ctrl_mask", TMR_CTRL, 32'h0000_000F);
    idle(20);
    wr(TMR_CTRL, 32'd0);
    idle(3);

    // Randomized traffic, checked every cycle by the compare process.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] d;
      logic [1:0]  a;
      if ($urandom_range(399) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
      a = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
        d = $urandom;
        if (a == TMR_CTRL && $urandom_range(3) != 0) d[0] = 1'b1;
        if (a == TMR_PRESET) d = $urandom_range(6);
        wr(a, d);
      end else begin
        bus.Addr = a;
        idle(1);
      end
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
